uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//   Receive-side byte buffer that sits directly downstream of the UART receiver.
//   - Captures each byte flagged by the receiver's one-cycle data-available strobe.
//   - Holds bytes until the consumer logic (command decoder / host bus) takes them
//     over a valid/ready handshake.
//   - Flags, and does not corrupt the stored data on, overflow when the consumer
//     falls behind line rate.
// PARAMETERS
//   DEPTH   16  number of byte entries; power of two, >= 2
//   AFULL   12  o_almost_full asserts when o_count >= AFULL; range 1..DEPTH
//   ADDR_W  $clog2(DEPTH)  pointer width; derived, do not override
// PORTS
//   clk             in   1         system clock, same clock as the UART receiver
//   i_rst           in   1         synchronous, active-high reset
//   i_data_avail    in   1         push strobe from the receiver, one cycle per byte
//   i_data_byte     in   8         byte to push; valid only while i_data_avail=1
//   o_valid         out  1         FIFO not empty; o_data holds the oldest byte
//   o_data          out  8         oldest byte (first-word-fall-through)
//   i_ready         in   1         consumer accepts o_data when o_valid & i_ready
//   o_count         out  ADDR_W+1  bytes currently stored, 0..DEPTH
//   o_full          out  1         o_count == DEPTH
//   o_almost_full   out  1         o_count >= AFULL (flow-control hint for the host)
//   o_overflow      out  1         sticky: a byte was dropped because the FIFO was full
//   i_clr_overflow  in   1         one-cycle pulse that clears o_overflow
// BEHAVIOUR
//   Reset
//   - One clock and one reset only. i_rst is synchronous and active-high;
//     all flops update on posedge clk.
//   - On i_rst: rd_ptr=0, wr_ptr=0, count=0, o_overflow=0.
//     Hence o_valid=0, o_full=0, o_almost_full=0, o_count=0.
//   - Memory contents are not reset. o_data is don't-care while o_valid=0.
//   - i_rst overrides every other input in the same cycle.
//   - Reset during traffic discards all stored bytes. The first push after
//     reset lands at entry 0.
//   Push and pop qualification
//   - push = i_data_avail & (~o_full | pop).
//   - pop  = o_valid & i_ready. i_ready has no effect while o_valid=0.
//   - On push: mem[wr_ptr] <= i_data_byte; wr_ptr increments.
//   - On pop: rd_ptr increments.
//   - Both pointers are ADDR_W bits and wrap from DEPTH-1 to 0 naturally.
//   - count <= count + push - pop, computed ADDR_W+1 bits wide.
//   Latency and output
//   - A byte pushed into an empty FIFO appears on o_data, with o_valid=1, on the
//     next cycle. There is no same-cycle bypass.
//   - o_data = mem[rd_ptr] (combinational read). It stays stable while
//     o_valid=1 and no pop occurs.
//   - All status outputs (o_count, o_full, o_almost_full, o_valid) are
//     registered or derived from registered count. They reflect state after the
//     previous edge.
//   Boundary cases
//   - Full, push, no pop: byte dropped; pointers and count unchanged;
//     o_overflow <= 1.
//   - Full, push and pop together: both happen; count stays DEPTH; no overflow.
//   - Empty, push and i_ready together: push only (o_valid was 0). Count
//     becomes 1.
//   - Non-empty, push and pop together: count unchanged; the byte order is
//     preserved.
//   Overflow flag
//   - Overflow event and i_clr_overflow in the same cycle: the event wins and
//     o_overflow stays 1.
//   - o_overflow stays 1 until i_clr_overflow or i_rst.
//   - Upstream rate: i_data_avail is never asserted on consecutive cycles. The
//     FIFO must not rely on this and must handle a strobe every cycle correctly.
// TESTING
//   1. Reset, then push 0xA5.
//      -> next cycle o_valid=1, o_data=0xA5, o_count=1.
//      -> pop it: o_valid=0, o_count=0.
//   2. Push 0x00..0x0F (DEPTH=16) with i_ready=0.
//      -> o_full=1, o_count=16; o_almost_full set from the 12th byte on.
//      -> drain: bytes come out 0x00..0x0F in order.
//   3. FIFO full; push 0x55 with i_ready=0.
//      -> o_overflow=1, o_count=16, the drain sequence is unchanged.
//      -> pulse i_clr_overflow: o_overflow=0.
//   4. FIFO full; push 0x77 with pop in the same cycle.
//      -> o_count stays 16, o_overflow=0, 0x77 is the last byte drained.
//   5. Wrap test: push and pop 40 random bytes with i_ready random.
//      -> output sequence equals input sequence; o_count never exceeds 16.
//   6. Load 5 bytes, assert i_rst while pushing 0x99.
//      -> next cycle o_count=0, o_valid=0, o_overflow=0.
//      -> the next push 0x3C is the first byte out.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO placed directly after the UART receiver.
// Captures strobed bytes and presents them first-word-fall-through on a
// valid/ready interface. When a byte arrives while full, it is dropped,
// the stored data is left intact, and a sticky overflow flag is raised.
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int AFULL  = 12,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_data_avail,
  input  logic [7:0]        i_data_byte,
  output logic              o_valid,
  output logic [7:0]        o_data,
  input  logic              i_ready,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full,
  output logic              o_almost_full,
  output logic              o_overflow,
  input  logic              i_clr_overflow
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_C = (ADDR_W+1)'(AFULL);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              push;
  logic              pop;
  logic              drop;

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  always_comb begin
    pop  = o_valid & i_ready;
    push = i_data_avail & (~o_full | pop);
    drop = i_data_avail & o_full & ~pop;
  end

  // Byte storage; contents are never reset, only the pointers are.
  always_ff @(posedge clk) begin
    if (push && !i_rst) begin
      mem[wr_ptr] <= i_data_byte;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{ADDR_W{1'b0}}, push} - {{ADDR_W{1'b0}}, pop};
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (i_clr_overflow) begin
      overflow <= 1'b0;
    end
  end

  // Status is derived from registered state only.
  always_comb begin
    o_valid       = (count != '0);
    o_data        = mem[rd_ptr];
    o_count       = count;
    o_full        = (count == DEPTH_C);
    o_almost_full = (count >= AFULL_C);
    o_overflow    = overflow;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: a queue-based reference model tracks
// accepted bytes, occupancy and the overflow flag; a monitor compares every
// DUT output against it on the falling edge.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int AFULL = 12;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_data_avail = 1'b0;
  logic [7:0]    i_data_byte = 8'h00;
  logic          o_valid;
  logic [7:0]    o_data;
  logic          i_ready = 1'b0;
  logic [AW:0]   o_count;
  logic          o_full;
  logic          o_almost_full;
  logic          o_overflow;
  logic          i_clr_overflow = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] exp_q[$];
  int         mcount = 0;
  logic       movf = 1'b0;

  uart_rx_fifo #(.DEPTH(DEPTH), .AFULL(AFULL)) dut (
    .clk(clk),
    .i_rst(i_rst),
    .i_data_avail(i_data_avail),
    .i_data_byte(i_data_byte),
    .o_valid(o_valid),
    .o_data(o_data),
    .i_ready(i_ready),
    .o_count(o_count),
    .o_full(o_full),
    .o_almost_full(o_almost_full),
    .o_overflow(o_overflow),
    .i_clr_overflow(i_clr_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte is taken when there is room or a byte leaves the
  // same cycle; otherwise it is lost and the flag is raised.
  always @(posedge clk) begin
    if (i_rst) begin
      exp_q.delete();
      mcount = 0;
      movf   = 1'b0;
    end else begin
      logic will_pop;
      logic room;
      will_pop = (mcount > 0) && i_ready;
      room     = (mcount < DEPTH) || will_pop;
      if (will_pop) mcount = mcount - 1;
      if (i_data_avail && room) begin
        exp_q.push_back(i_data_byte);
        mcount = mcount + 1;
      end
      if (i_data_avail && !room) movf = 1'b1;
      else if (i_clr_overflow)   movf = 1'b0;
    end
  end

  // Monitor: status every cycle, data whenever the DUT presents a byte.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("count", 32'(o_count), 32'(mcount));
      chk("valid", 32'(o_valid), 32'(mcount > 0));
      chk("full", 32'(o_full), 32'(mcount == DEPTH));
      chk("almost_full", 32'(o_almost_full), 32'(mcount >= AFULL));
      chk("overflow", 32'(o_overflow), 32'(movf));
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          chk("data_unexpected", 32'(o_data), 32'hFFFF_FFFF);
        end else begin
          chk("data", 32'(o_data), 32'(exp_q[0]));
          if (i_ready && !i_rst) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic step(input logic av, input logic [7:0] b, input logic rdy,
                      input logic clr, input logic rst);
    i_data_avail   = av;
    i_data_byte    = b;
    i_ready        = rdy;
    i_clr_overflow = clr;
    i_rst          = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (mcount != 0 && n < 4 * DEPTH) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      n++;
    end
    chk("drain_done", 32'(mcount), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int pushed;
    @(posedge clk);
    #1;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Single byte latency and pop
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Empty with push and ready together
    step(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
    drain();

    // Fill to full, back-to-back strobes
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Overflow, clear, then overflow racing a clear
    step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h66, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Full with simultaneous push and pop
    step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    drain();

    // Random traffic across several pointer wraps
    pushed = 0;
    for (int c = 0; c < 2000 && pushed < 40; c++) begin
      logic av;
      av = ($urandom_range(0, 1) == 1);
      if (av) pushed++;
      step(av, 8'($urandom), ($urandom_range(0, 2) != 0), 1'b0, 1'b0);
    end
    drain();

    // Random traffic biased towards overflow, with random clears
    for (int c = 0; c < 120; c++) begin
      step(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0), 1'b0);
    end
    drain();
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Reset during traffic
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h4D, 1'b0, 1'b0, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
